id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline stage directly upstream of the EX-stage ALU in the 5-stage MIPS32 core.
- Registers decoded operands and controls from ID.
- Drives the ALU's SrcA, SrcB and 4-bit ALUControl through operand-select and EX/MEM, MEM/WB forwarding muxes.
- Provides stall hold, flush bubble, and automatic load-use bubble insertion.

Parameters:
- DW, 32, datapath width; must equal the ALU operand width.
- RW, 5, register-specifier width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold this stage (downstream wait).
- flush  in  1  replace the next stage contents with a bubble (branch/exception).
- id_valid  in  1  ID holds a real instruction.
- id_rs_data, id_rt_data  in  DW  register-file read data.
- id_imm  in  DW  already-extended immediate.
- id_shamt  in  5  shift amount field.
- id_rs, id_rt, id_rd_dst  in  RW  source and destination specifiers.
- id_alu_ctrl  in  4  ALU op code, same encoding as the ALU (AND=0000 … SLTU=1011).
- id_alusrc_b  in  1  1: SrcB = immediate.
- id_shift_src  in  1  1: SrcA = zero-extended shamt.
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1  stage controls.
- mem_reg_write  in  1  EX/MEM forwarding source; mem_rd  in  RW; mem_result  in  DW.
- wb_reg_write  in  1  MEM/WB forwarding source; wb_rd  in  RW; wb_result  in  DW.
- SrcA, SrcB  out  DW  ALU operands.
- ALUControl  out  4  registered ALU op.
- ex_store_data  out  DW  forwarded rt value for stores.
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1  registered controls.
- ex_rd, ex_rs, ex_rt  out  RW  registered specifiers.
- load_use_hazard  out  1  combinational; ID must hold while it is asserted.

Behaviour:
- Reset (async, mid-operation included): all registers 0. ex_valid=0, all controls 0, ALUControl=4'b0000. SrcA=SrcB=0 while nothing forwards.
- load_use_hazard = ex_valid & ex_mem_read & (ex_rd!=0) & id_valid & (ex_rd==id_rs | ex_rd==id_rt).
- Register update priority per rising edge:
  - flush: bubble.
  - else stall: hold all registers.
  - else load_use_hazard: bubble.
  - else load all id_* values.
- Bubble: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg = 0. ALUControl=0. Data and specifier registers hold.
- flush together with stall: flush wins, so the EX contents become a bubble.
- Latency: one cycle from ID inputs to registered outputs. Forwarding muxes are combinational on the registered values.
- Forward A, evaluated on ex_rs:
  - EX/MEM when mem_reg_write & mem_rd!=0 & mem_rd==ex_rs;
  - else MEM/WB when wb_reg_write & wb_rd!=0 & wb_rd==ex_rs;
  - else registered rs data.
  - EX/MEM beats MEM/WB when both match.
- Forward B: same rule on ex_rt, giving fwdB.
- SrcA = ex_shift_src ? {27'b0, ex_shamt} : fwdA.
- SrcB = ex_alusrc_b ? ex_imm : fwdB.
- ex_store_data = fwdB, always the forwarded value, never the immediate.
- Register $0 is never forwarded. Forward inputs are ignored when their reg_write is 0.

Optional Feature:
- Macro: IDEX_FORWARD_EN.
- Defined: forwarding as specified above.
- Undefined:
  - fwdA and fwdB are the registered register-file data; mem_*/wb_* inputs are unused.
  - load_use_hazard widens to any valid EX instruction with ex_reg_write & ex_rd!=0 matching id_rs or id_rt.
  - ID must then additionally wait for writeback through the core's stall logic.

Test Plan:
- Reset pulse mid-stream with id_valid=1 → ex_valid=0, ALUControl=0, SrcA=SrcB=0 asynchronously. First edge after release loads the ID values.
- ADD $3,$1,$2 (rs=0x5, rt=0x7, ctrl=0100) then stall=1 for 3 cycles → outputs hold: SrcA=5, SrcB=7, ALUControl=0100.
- Forward priority:
  - ex_rs=4, mem_rd=4, mem_result=0xAAAA0000, wb_rd=4, wb_result=0x12345678, both reg_write=1 → SrcA=0xAAAA0000.
  - Same with mem_reg_write=0 → SrcA=0x12345678.
  - Same with ex_rs=0 → no forwarding.
- LW $8 in EX (ex_mem_read=1, ex_rd=8) and ID reads rt=8 → load_use_hazard=1; next edge ex_valid=0, ex_reg_write=0.
- SLL with shamt=3, id_shift_src=1, id_alusrc_b=0, rt=0x1 → SrcA=0x3, SrcB=0x1, ALUControl=0110. SW with imm=0x10 and rt forwarded 0xDEAD → SrcB=0x10, ex_store_data=0xDEAD.
- flush=1 and stall=1 together → bubble loaded (ex_valid=0). With IDEX_FORWARD_EN undefined, the matching mem_rd does not alter SrcA.

Source files
------------

// File: rtl/id_ex_if.sv
// id_ex_if: ID/EX stage bus grouping ID inputs, stage controls, forwarding sources and the EX-side outputs.
// master: ID/control side (drives id_*, stall, flush, mem_*, wb_*); slave: the ID/EX stage.
interface id_ex_if #(parameter int DW = 32, parameter int RW = 5);
  logic          stall, flush, id_valid;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]    id_shamt;
  logic [RW-1:0] id_rs, id_rt, id_rd_dst;
  logic [3:0]    id_alu_ctrl;
  logic          id_alusrc_b, id_shift_src;
  logic          id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic          mem_reg_write, wb_reg_write;
  logic [RW-1:0] mem_rd, wb_rd;
  logic [DW-1:0] mem_result, wb_result;
  logic [DW-1:0] SrcA, SrcB, ex_store_data;
  logic [3:0]    ALUControl;
  logic          ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic [RW-1:0] ex_rd, ex_rs, ex_rt;
  logic          load_use_hazard;
  modport master (
    output stall, flush, id_valid, id_rs_data, id_rt_data, id_imm, id_shamt,
           id_rs, id_rt, id_rd_dst, id_alu_ctrl, id_alusrc_b, id_shift_src,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
           mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_result,
    input  SrcA, SrcB, ALUControl, ex_store_data, ex_valid, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_rd, ex_rs, ex_rt, load_use_hazard
  );
  modport slave (
    input  stall, flush, id_valid, id_rs_data, id_rt_data, id_imm, id_shamt,
           id_rs, id_rt, id_rd_dst, id_alu_ctrl, id_alusrc_b, id_shift_src,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
           mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_result,
    output SrcA, SrcB, ALUControl, ex_store_data, ex_valid, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_rd, ex_rs, ex_rt, load_use_hazard
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding the ALU, with stall hold, flush/load-use bubbles and operand forwarding.
// Ports: clk, reset (async, active-high), bus (id_ex_if.slave: ID inputs, stall/flush, EX/MEM + MEM/WB forward sources, ALU operands and EX controls).
// IDEX_FORWARD_EN: when defined, EX/MEM and MEM/WB forwarding is enabled; otherwise register-file data is used
// directly and the load-use hazard widens to any register-writing instruction in EX.
module id_ex_stage #(parameter int DW = 32, parameter int RW = 5) (
  input logic clk,
  input logic reset,
  id_ex_if.slave bus
);
  typedef struct packed {
    logic          valid, reg_write, mem_read, mem_write, mem_to_reg, alusrc_b, shift_src;
    logic [3:0]    alu_ctrl;
    logic [DW-1:0] rs_data, rt_data, imm;
    logic [4:0]    shamt;
    logic [RW-1:0] rs, rt, rd;
  } ex_t;
  ex_t st_d, st_q;
  logic          src_match, hazard;
  logic [DW-1:0] fwd_a, fwd_b;
  assign src_match = (st_q.rd == bus.id_rs) | (st_q.rd == bus.id_rt);
`ifdef IDEX_FORWARD_EN
  assign hazard = st_q.valid & st_q.mem_read & (st_q.rd != '0) & bus.id_valid & src_match;
  assign fwd_a = (bus.mem_reg_write && bus.mem_rd != '0 && bus.mem_rd == st_q.rs) ? bus.mem_result :
                 (bus.wb_reg_write && bus.wb_rd != '0 && bus.wb_rd == st_q.rs) ? bus.wb_result : st_q.rs_data;
  assign fwd_b = (bus.mem_reg_write && bus.mem_rd != '0 && bus.mem_rd == st_q.rt) ? bus.mem_result :
                 (bus.wb_reg_write && bus.wb_rd != '0 && bus.wb_rd == st_q.rt) ? bus.wb_result : st_q.rt_data;
`else
  // Without forwarding every pending register write in EX must drain before a dependent instruction enters.
  assign hazard = st_q.valid & (st_q.reg_write | st_q.mem_read) & (st_q.rd != '0) & bus.id_valid & src_match;
  assign fwd_a = st_q.rs_data;
  assign fwd_b = st_q.rt_data;
  logic unused_fwd;
  assign unused_fwd = ^{bus.mem_reg_write, bus.mem_rd, bus.mem_result, bus.wb_reg_write, bus.wb_rd, bus.wb_result};
`endif
  always_comb begin
    st_d = st_q;
    if (bus.flush || (!bus.stall && hazard)) begin
      // A bubble clears only the controls; data and specifiers keep their old values.
      st_d.valid      = 1'b0;
      st_d.reg_write  = 1'b0;
      st_d.mem_read   = 1'b0;
      st_d.mem_write  = 1'b0;
      st_d.mem_to_reg = 1'b0;
      st_d.alu_ctrl   = 4'b0000;
    end else if (!bus.stall) begin
      st_d.valid      = bus.id_valid;
      st_d.reg_write  = bus.id_reg_write;
      st_d.mem_read   = bus.id_mem_read;
      st_d.mem_write  = bus.id_mem_write;
      st_d.mem_to_reg = bus.id_mem_to_reg;
      st_d.alusrc_b   = bus.id_alusrc_b;
      st_d.shift_src  = bus.id_shift_src;
      st_d.alu_ctrl   = bus.id_alu_ctrl;
      st_d.rs_data    = bus.id_rs_data;
      st_d.rt_data    = bus.id_rt_data;
      st_d.imm        = bus.id_imm;
      st_d.shamt      = bus.id_shamt;
      st_d.rs         = bus.id_rs;
      st_d.rt         = bus.id_rt;
      st_d.rd         = bus.id_rd_dst;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) st_q <= '0;
    else st_q <= st_d;
  assign bus.SrcA            = st_q.shift_src ? {{(DW-5){1'b0}}, st_q.shamt} : fwd_a;
  assign bus.SrcB            = st_q.alusrc_b ? st_q.imm : fwd_b;
  assign bus.ex_store_data   = fwd_b;
  assign bus.ALUControl      = st_q.alu_ctrl;
  assign bus.ex_valid        = st_q.valid;
  assign bus.ex_reg_write    = st_q.reg_write;
  assign bus.ex_mem_read     = st_q.mem_read;
  assign bus.ex_mem_write    = st_q.mem_write;
  assign bus.ex_mem_to_reg   = st_q.mem_to_reg;
  assign bus.ex_rd           = st_q.rd;
  assign bus.ex_rs           = st_q.rs;
  assign bus.ex_rt           = st_q.rt;
  assign bus.load_use_hazard = hazard;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage; expectations follow IDEX_FORWARD_EN.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
`ifdef IDEX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  id_ex_if #(.DW(32), .RW(5)) bus ();
  id_ex_stage #(.DW(32), .RW(5)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic set_id(input logic [4:0] rs, rt, rd, input logic [31:0] rs_d, rt_d, imm,
                        input logic [3:0] ctrl, input logic [4:0] shamt, input logic asb, ssrc,
                        input logic rw, mr, mw, m2r);
    bus.id_valid = 1'b1; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd_dst = rd;
    bus.id_rs_data = rs_d; bus.id_rt_data = rt_d; bus.id_imm = imm; bus.id_alu_ctrl = ctrl;
    bus.id_shamt = shamt; bus.id_alusrc_b = asb; bus.id_shift_src = ssrc;
    bus.id_reg_write = rw; bus.id_mem_read = mr; bus.id_mem_write = mw; bus.id_mem_to_reg = m2r;
  endtask
  initial begin
    bus.stall = 0; bus.flush = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.id_valid = 0;
    bus.mem_reg_write = 0; bus.mem_rd = 0; bus.mem_result = 0;
    bus.wb_reg_write = 0; bus.wb_rd = 0; bus.wb_result = 0;
    #1 reset = 1;
    #2;
    chk("rst_valid", {31'b0, bus.ex_valid}, 32'd0);
    chk("rst_ctrl", {28'b0, bus.ALUControl}, 32'd0);
    chk("rst_srca", bus.SrcA, 32'd0);
    chk("rst_srcb", bus.SrcB, 32'd0);
    tick();
    // ADD $3,$1,$2 with rs=5, rt=7
    set_id(1, 2, 3, 32'h5, 32'h7, 32'h0, 4'b0100, 0, 0, 0, 1, 0, 0, 0);
    reset = 0;
    tick();
    chk("add_valid", {31'b0, bus.ex_valid}, 32'd1);
    chk("add_srca", bus.SrcA, 32'h5);
    chk("add_srcb", bus.SrcB, 32'h7);
    chk("add_ctrl", {28'b0, bus.ALUControl}, 32'b0100);
    chk("add_rd", {27'b0, bus.ex_rd}, 32'd3);
    // stall 3 cycles while ID changes underneath
    bus.stall = 1;
    set_id(9, 9, 9, 32'h99, 32'h98, 32'h97, 4'hF, 7, 1, 1, 0, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_srca", bus.SrcA, 32'h5);
      chk("stall_srcb", bus.SrcB, 32'h7);
      chk("stall_ctrl", {28'b0, bus.ALUControl}, 32'b0100);
    end
    bus.stall = 0;
    // asynchronous reset pulse mid-stream with a valid ID instruction present
    #2 reset = 1;
    #1;
    chk("arst_valid", {31'b0, bus.ex_valid}, 32'd0);
    chk("arst_ctrl", {28'b0, bus.ALUControl}, 32'd0);
    chk("arst_srca", bus.SrcA, 32'd0);
    chk("arst_srcb", bus.SrcB, 32'd0);
    #1 reset = 0;
    set_id(4, 5, 6, 32'h11, 32'h22, 32'h0, 4'b0010, 0, 0, 0, 1, 0, 0, 0);
    tick();
    chk("post_rst_valid", {31'b0, bus.ex_valid}, 32'd1);
    chk("post_rst_srca", bus.SrcA, 32'h11);
    chk("post_rst_rs", {27'b0, bus.ex_rs}, 32'd4);
    // forwarding priority on ex_rs=4
    bus.mem_reg_write = 1; bus.mem_rd = 4; bus.mem_result = 32'hAAAA0000;
    bus.wb_reg_write = 1; bus.wb_rd = 4; bus.wb_result = 32'h12345678;
    #1 chk("fwd_mem_wins", bus.SrcA, FWD ? 32'hAAAA0000 : 32'h11);
    bus.mem_reg_write = 0;
    #1 chk("fwd_wb", bus.SrcA, FWD ? 32'h12345678 : 32'h11);
    set_id(0, 5, 6, 32'h33, 32'h22, 32'h0, 4'b0010, 0, 0, 0, 1, 0, 0, 0);
    tick();
    bus.mem_reg_write = 1; bus.mem_rd = 0; bus.wb_rd = 0;
    #1 chk("fwd_r0", bus.SrcA, 32'h33);
    bus.mem_reg_write = 0; bus.wb_reg_write = 0;
    // LW $8 then a consumer of $8
    set_id(1, 8, 8, 32'h100, 32'h0, 32'h4, 4'b0010, 0, 1, 0, 1, 1, 0, 1);
    tick();
    chk("lw_memread", {31'b0, bus.ex_mem_read}, 32'd1);
    set_id(2, 8, 11, 32'h1, 32'h2, 32'h0, 4'b0100, 0, 0, 0, 1, 0, 0, 0);
    #1 chk("lu_hazard", {31'b0, bus.load_use_hazard}, 32'd1);
    tick();
    chk("lu_valid", {31'b0, bus.ex_valid}, 32'd0);
    chk("lu_regwrite", {31'b0, bus.ex_reg_write}, 32'd0);
    chk("lu_ctrl", {28'b0, bus.ALUControl}, 32'd0);
    chk("lu_rd_hold", {27'b0, bus.ex_rd}, 32'd8);
    chk("lu_clear", {31'b0, bus.load_use_hazard}, 32'd0);
    tick();
    chk("lu_resume_valid", {31'b0, bus.ex_valid}, 32'd1);
    chk("lu_resume_rd", {27'b0, bus.ex_rd}, 32'd11);
    // SLL: SrcA = shamt, SrcB = rt data
    set_id(0, 9, 10, 32'h0, 32'h1, 32'h0, 4'b0110, 3, 0, 1, 1, 0, 0, 0);
    tick();
    chk("sll_srca", bus.SrcA, 32'h3);
    chk("sll_srcb", bus.SrcB, 32'h1);
    chk("sll_ctrl", {28'b0, bus.ALUControl}, 32'b0110);
    // ALU result dependency: stalls only without forwarding
    set_id(10, 12, 0, 32'h55, 32'h1111, 32'h10, 4'b0010, 0, 1, 0, 0, 0, 1, 0);
    #1 chk("alu_dep_hazard", {31'b0, bus.load_use_hazard}, FWD ? 32'd0 : 32'd1);
    // SW with imm=0x10, rt forwarded
    set_id(13, 12, 0, 32'h55, 32'h1111, 32'h10, 4'b0010, 0, 1, 0, 0, 0, 1, 0);
    tick();
    bus.mem_reg_write = 1; bus.mem_rd = 12; bus.mem_result = 32'hDEAD;
    #1;
    chk("sw_srcb", bus.SrcB, 32'h10);
    chk("sw_store", bus.ex_store_data, FWD ? 32'hDEAD : 32'h1111);
    chk("sw_memwrite", {31'b0, bus.ex_mem_write}, 32'd1);
    // flush together with stall: bubble wins
    bus.stall = 1; bus.flush = 1;
    tick();
    bus.stall = 0; bus.flush = 0;
    chk("flush_valid", {31'b0, bus.ex_valid}, 32'd0);
    chk("flush_memwrite", {31'b0, bus.ex_mem_write}, 32'd0);
    chk("flush_ctrl", {28'b0, bus.ALUControl}, 32'd0);
    bus.mem_rd = 13; bus.mem_result = 32'hBEEF;
    #1 chk("flush_srca", bus.SrcA, FWD ? 32'hBEEF : 32'h55);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
